// File: rtl/encoder_emu.sv
// encoder_emu: motor-plus-encoder emulator turning PWM duty into an encoder pulse train (option: ENCEMU_INERTIA_EN)
module encoder_emu #(
  parameter int CLK_HZ        = 16000000,
  parameter int PWM_PERIOD    = 1000,
  parameter int MAX_TICK_RATE = 1200,
  parameter int PULSE_WIDTH   = 8
) (
  input  logic        WF_CLK,
  input  logic        rst,
  input  logic        motor_pwm,
  input  logic        motor_en,
  input  logic        motor_dir,
  output logic        motor_encdr,
  output logic [15:0] duty,
  output logic [15:0] position,
  output logic        overrun
);
  localparam logic [39:0] THRESH = 40'(CLK_HZ) * 40'(PWM_PERIOD);
  localparam logic [15:0] PW_M1  = 16'(PULSE_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t      state, state_nx;
  logic [15:0] win_cnt, hi_cnt, ph, ph_nx, rate_duty;
  logic [39:0] acc, inc;
  logic [40:0] sum;
  logic [1:0]  pending, pending_nx;
  logic [2:0]  pend_sum, pend_dec;
  logic        smp, win_end, tick, leave_low, start, ovf;
  assign smp     = motor_pwm & motor_en;
  assign win_end = win_cnt == 16'(PWM_PERIOD - 1);
  // duty window: count high samples, publish the total at the window end
  always_ff @(posedge WF_CLK)
    if (rst) begin
      win_cnt <= '0;
      hi_cnt  <= '0;
      duty    <= '0;
    end else if (win_end) begin
      duty    <= hi_cnt + 16'(smp);
      hi_cnt  <= '0;
      win_cnt <= '0;
    end else begin
      hi_cnt  <= hi_cnt + 16'(smp);
      win_cnt <= win_cnt + 16'd1;
    end
`ifdef ENCEMU_INERTIA_EN
  logic [15:0]        duty_eff, duty_new, eff_nx, eff_snap;
  logic signed [16:0] diff, step, step_m;
  assign duty_new = hi_cnt + 16'(smp);
  assign diff     = $signed({1'b0, duty_new}) - $signed({1'b0, duty_eff});
  assign step     = diff >>> 2;
  assign step_m   = step != 17'sd0 ? step : diff > 17'sd0 ? 17'sd1 : diff < 17'sd0 ? -17'sd1 : 17'sd0;
  assign eff_nx   = 16'($signed({1'b0, duty_eff}) + step_m);
  assign eff_snap = (duty_new - eff_nx == 16'd1 || eff_nx - duty_new == 16'd1) ? duty_new : eff_nx;
  // filtered duty: a quarter of the gap per window, never stalling short of the target
  always_ff @(posedge WF_CLK)
    if (rst || !motor_en) duty_eff <= '0;
    else if (win_end) duty_eff <= eff_snap;
  assign rate_duty = duty_eff;
`else
  assign rate_duty = duty;
`endif
  assign inc  = 40'(rate_duty) * 40'(MAX_TICK_RATE);
  assign sum  = {1'b0, acc} + {1'b0, inc};
  assign tick = motor_en && sum >= {1'b0, THRESH};
  // rate accumulator: a tick every time the scaled duty crosses the threshold
  always_ff @(posedge WF_CLK)
    if (rst || !motor_en) acc <= '0;
    else acc <= tick ? 40'(sum - {1'b0, THRESH}) : sum[39:0];
  assign leave_low = state == LOW && ph == PW_M1;
  assign pend_sum  = {1'b0, pending} + 3'(tick && state != IDLE);
  assign start     = (state == IDLE && tick) || (leave_low && motor_en && pend_sum != 3'd0);
  assign pend_dec  = pend_sum - 3'(start && state == LOW);
  assign ovf       = pend_dec[2];
  // pulse sequencing: start, phase advance, and pending bookkeeping
  always_comb begin
    state_nx   = start ? HIGH : (state == HIGH && ph == PW_M1) ? LOW : leave_low ? IDLE : state;
    ph_nx      = (start || state_nx != state || state == IDLE) ? 16'd0 : ph + 16'd1;
    pending_nx = !motor_en ? 2'd0 : ovf ? 2'd3 : pend_dec[1:0];
  end
  // pulse state, pending ticks, position and sticky overrun
  always_ff @(posedge WF_CLK)
    if (rst) begin
      state    <= IDLE;
      ph       <= '0;
      pending  <= '0;
      position <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      ph       <= ph_nx;
      pending  <= pending_nx;
      overrun  <= overrun | ovf;
      position <= start ? position + (motor_dir ? 16'hFFFF : 16'd1) : position;
    end
  assign motor_encdr = state == HIGH;
endmodule

// File: tb/tb_encoder_emu.sv
// tb_encoder_emu: randomized check of two encoder_emu instances against a behavioural model
module tb_encoder_emu;
  localparam int     P  = 10;
  localparam int     PW = 2;
  localparam longint TH = 10000;
  logic        WF_CLK = 0, rst, pwm, en, dir;
  logic        enc [2];
  logic        ovr_o [2];
  logic [15:0] duty_o [2], pos_o [2];
  int          checks = 0, errors = 0, cyc = 0;
  int          rate [2] = '{100, 1000};
  int          m_win [2], m_hsum [2], m_duty [2], m_ps [2], m_pend [2];
  longint      m_acc [2];
  logic [15:0] m_pos [2];
  bit          m_ovr [2];
  encoder_emu #(.CLK_HZ(1000), .PWM_PERIOD(P), .MAX_TICK_RATE(100), .PULSE_WIDTH(PW)) u_a (
    .WF_CLK(WF_CLK), .rst(rst), .motor_pwm(pwm), .motor_en(en), .motor_dir(dir),
    .motor_encdr(enc[0]), .duty(duty_o[0]), .position(pos_o[0]), .overrun(ovr_o[0]));
  encoder_emu #(.CLK_HZ(1000), .PWM_PERIOD(P), .MAX_TICK_RATE(1000), .PULSE_WIDTH(PW)) u_b (
    .WF_CLK(WF_CLK), .rst(rst), .motor_pwm(pwm), .motor_en(en), .motor_dir(dir),
    .motor_encdr(enc[1]), .duty(duty_o[1]), .position(pos_o[1]), .overrun(ovr_o[1]));
  always #5 WF_CLK = ~WF_CLK;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit     smp, tk, busy, last, start;
      int     s;
      longint a;
      if (rst) begin
        m_win[i] = 0; m_hsum[i] = 0; m_duty[i] = 0; m_acc[i] = 0;
        m_ps[i] = -100; m_pend[i] = 0; m_pos[i] = 0; m_ovr[i] = 0;
      end else begin
        smp = pwm & en;
        a = m_acc[i] + longint'(m_duty[i]) * rate[i];
        tk = en && a >= TH;
        m_acc[i] = !en ? 0 : tk ? a - TH : a;
        busy = cyc - m_ps[i] < 2 * PW;
        last = cyc - m_ps[i] == 2 * PW - 1;
        s = m_pend[i] + int'(tk && busy);
        start = (!busy && tk) || (last && en && s > 0);
        if (last && en && s > 0) s--;
        if (!en) m_pend[i] = 0;
        else if (s > 3) begin m_pend[i] = 3; m_ovr[i] = 1; end
        else m_pend[i] = s;
        if (start) begin
          m_ps[i] = cyc + 1;
          m_pos[i] = m_pos[i] + (dir ? 16'hFFFF : 16'd1);
        end
        if (m_win[i] == P - 1) begin
          m_duty[i] = m_hsum[i] + int'(smp); m_hsum[i] = 0; m_win[i] = 0;
        end else begin
          m_hsum[i] += int'(smp); m_win[i]++;
        end
      end
    end
    cyc++;
  endtask
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("encdr[%0d]", i), int'(enc[i]), int'(cyc - m_ps[i] < PW));
      check($sformatf("duty[%0d]", i), int'(duty_o[i]), m_duty[i]);
      check($sformatf("position[%0d]", i), int'(pos_o[i]), int'(m_pos[i]));
      check($sformatf("overrun[%0d]", i), int'(ovr_o[i]), int'(m_ovr[i]));
    end
  endtask
  task automatic cycle();
    @(posedge WF_CLK);
    model_step();
    @(negedge WF_CLK);
    compare();
  endtask
  initial begin
    int   found, cnt, dtarget;
    logic [15:0] p0, d;
    rst = 1; en = 0; pwm = 0; dir = 0;
    repeat (5) begin
      pwm = 1'($urandom); en = 1'($urandom); dir = 1'($urandom);
      cycle();
      check("rst_encdr", int'(enc[0]), 0);
      check("rst_position", int'(pos_o[0]), 0);
    end
    rst = 0; en = 1; pwm = 1; dir = 0;
    repeat (P) cycle();
    check("duty_first_window", int'(duty_o[0]), 10);
    repeat (8) cycle();
    check("overrun_b_set", int'(ovr_o[1]), 1);
    p0 = pos_o[0];
    repeat (200) cycle();
    d = pos_o[0] - p0;
    check("steady_rate_20", int'(d >= 16'd19 && d <= 16'd21), 1);
    check("overrun_b_sticky", int'(ovr_o[1]), 1);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      cycle();
      found = int'(enc[0]);
    end
    check("en_drop_found_pulse", found, 1);
    en = 0;
    cnt = 0;
    repeat (8) begin
      cycle();
      cnt += int'(enc[0]);
    end
    check("en_drop_one_more_high", cnt, 1);
    rst = 1; cycle();
    rst = 0; en = 1; dir = 1;
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      pwm = (k % 10) < 5;
      cycle();
      found = int'(enc[0]);
    end
    check("rev_pulse_seen", found, 1);
    check("rev_first_position", int'(pos_o[0]), 65535);
    check("rev_duty_half", int'(duty_o[0]), 5);
    dtarget = 50;
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0) dtarget = $urandom_range(0, 100);
      if (k % 150 == 0) dir = 1'($urandom);
      rst = $urandom_range(0, 399) == 0;
      en = $urandom_range(0, 19) != 0;
      pwm = $urandom_range(0, 99) < dtarget;
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
